// File: rtl/gardner_pkg.sv
// Shared types and the signed clip helper for the Gardner timing-error detector.
package gardner_pkg;

  typedef enum logic {TED_IQ = 1'b0, TED_I_ONLY = 1'b1} ted_mode_e;
  typedef enum logic {FILL = 1'b0, RUN = 1'b1} ted_state_e;

  // Widest value the clip helper handles; the top checks its own widths against it.
  localparam int unsigned SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_s(input logic signed [SAT_W-1:0] value,
                                                    input int unsigned width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

endpackage

// File: rtl/ted_delay_line.sv
// Circular I/Q sample buffer with three tap-read ports.
// Tap k returns the sample written k valid samples ago; k=0 reads the oldest slot (k=DEPTH).
module ted_delay_line #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 21,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic signed [W-1:0] wr_i,
  input  logic signed [W-1:0] wr_q,
  input  logic [AW-1:0]       rd_k [3],
  output logic signed [W-1:0] rd_i [3],
  output logic signed [W-1:0] rd_q [3]
);

  logic signed [W-1:0] mem_i [DEPTH];
  logic signed [W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wp;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp <= '0;
      for (int unsigned n = 0; n < DEPTH; n++) begin
        mem_i[n] <= '0;
        mem_q[n] <= '0;
      end
    end else if (wr_en) begin
      mem_i[wp] <= wr_i;
      mem_q[wp] <= wr_q;
      wp        <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_rd
    logic [AW:0] sum;
    logic [AW:0] idx;
    always_comb begin
      sum = {1'b0, wp} + (AW+1)'(DEPTH) - {1'b0, rd_k[r]};
      idx = (sum >= (AW+1)'(DEPTH)) ? sum - (AW+1)'(DEPTH) : sum;
    end
    assign rd_i[r] = mem_i[idx[AW-1:0]];
    assign rd_q[r] = mem_q[idx[AW-1:0]];
  end

endmodule

// File: rtl/gardner_ted_pipe.sv
// Pipelined Gardner timing-error detector with saturated output and raw-delayed I/Q taps.
// Optional macro TED_AVG_EN adds a stage-3 average over 2^AVG_LOG2 errors.
module gardner_ted_pipe
  import gardner_pkg::*;
#(
  parameter int unsigned OSF      = 20,
  parameter int unsigned WI       = 16,
  parameter int unsigned WO       = 18,
  parameter int unsigned ESHIFT   = 14,
  parameter int unsigned RAW_DLY  = 20,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [WI-1:0] i_in,
  input  logic signed [WI-1:0] q_in,
  input  logic                 iq_val,
  input  logic                 sym_valid_i,
  input  logic                 mode_i,
  output logic signed [WO-1:0] e_out_o,
  output logic                 e_valid_o,
  output logic                 sat_o,
  output logic signed [WI-1:0] i_raw_delay_o,
  output logic signed [WI-1:0] q_raw_delay_o
);

  localparam int unsigned D  = OSF + 1;
  localparam int unsigned AW = $clog2(D);
  localparam int unsigned PW = 2 * WI + 1;
  localparam int unsigned SW = 2 * WI + 3;
  localparam logic [AW-1:0] K_HALF = AW'(OSF / 2);
  localparam logic [AW-1:0] K_PREV = AW'(OSF);
  localparam logic [AW-1:0] K_RAW  = AW'((RAW_DLY + 1) % D);

  if (OSF < 4 || (OSF % 2) != 0) begin : g_bad_osf
    $error("gardner_ted_pipe: OSF must be even and >= 4");
  end
  if (RAW_DLY > OSF) begin : g_bad_raw
    $error("gardner_ted_pipe: RAW_DLY must be in 0..OSF");
  end
  if (SW > SAT_W || WO > SAT_W || AVG_LOG2 > 16) begin : g_bad_width
    $error("gardner_ted_pipe: width parameters out of range");
  end

  logic [AW-1:0]        rd_k  [3];
  logic signed [WI-1:0] tap_i [3];
  logic signed [WI-1:0] tap_q [3];

  assign rd_k[0] = K_HALF;
  assign rd_k[1] = K_PREV;
  assign rd_k[2] = K_RAW;

  ted_delay_line #(.W(WI), .DEPTH(D)) u_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (iq_val),
    .wr_i    (i_in),
    .wr_q    (q_in),
    .rd_k    (rd_k),
    .rd_i    (tap_i),
    .rd_q    (tap_q)
  );

  assign i_raw_delay_o = tap_i[2];
  assign q_raw_delay_o = tap_q[2];

  ted_state_e    state;
  logic [AW-1:0] fill_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= FILL;
      fill_cnt <= '0;
    end else if (iq_val) begin
      if (fill_cnt != K_PREV) fill_cnt <= fill_cnt + 1'b1;
      case (state)
        FILL:    if (fill_cnt == AW'(OSF - 1)) state <= RUN;
        RUN:     state <= RUN;
        default: state <= FILL;
      endcase
    end
  end

  logic              strobe;
  logic signed [WI:0] d_i;
  logic signed [WI:0] d_q;

  assign strobe = iq_val && sym_valid_i && (state == RUN);
  assign d_i    = (WI+1)'(i_in) - (WI+1)'(tap_i[1]);
  assign d_q    = (WI+1)'(q_in) - (WI+1)'(tap_q[1]);

  logic                 s1_valid;
  logic signed [PW-1:0] p_i;
  logic signed [PW-1:0] p_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      p_i      <= '0;
      p_q      <= '0;
    end else begin
      s1_valid <= strobe;
      if (strobe) begin
        p_i <= PW'(tap_i[0]) * PW'(d_i);
        p_q <= (ted_mode_e'(mode_i) == TED_I_ONLY) ? '0 : PW'(tap_q[0]) * PW'(d_q);
      end
    end
  end

  logic signed [SW-1:0]    sum;
  logic signed [SW-1:0]    shifted;
  logic signed [SAT_W-1:0] wide;
  logic signed [SAT_W-1:0] clipped;

  always_comb begin
    sum     = SW'(p_i) + SW'(p_q);
    shifted = sum >>> ESHIFT;
    wide    = SAT_W'(shifted);
    clipped = sat_s(wide, WO);
  end

  logic                 s2_valid;
  logic signed [WO-1:0] s2_err;
  logic                 s2_sat;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_err   <= '0;
      s2_sat   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_sat   <= s1_valid && (clipped != wide);
      if (s1_valid) s2_err <= WO'(clipped);
    end
  end

`ifdef TED_AVG_EN
  localparam int unsigned ACW = WO + AVG_LOG2;
  localparam int unsigned CW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

  logic signed [ACW-1:0] acc;
  logic signed [ACW-1:0] acc_nxt;
  logic [CW-1:0]         cnt;
  logic                  sat_acc;

  assign acc_nxt = acc + ACW'(s2_err);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc       <= '0;
      cnt       <= '0;
      sat_acc   <= 1'b0;
      e_out_o   <= '0;
      e_valid_o <= 1'b0;
      sat_o     <= 1'b0;
    end else begin
      e_valid_o <= 1'b0;
      sat_o     <= 1'b0;
      if (s2_valid) begin
        if (cnt == LAST) begin
          e_out_o   <= WO'(acc_nxt >>> AVG_LOG2);
          e_valid_o <= 1'b1;
          sat_o     <= sat_acc | s2_sat;
          acc       <= '0;
          cnt       <= '0;
          sat_acc   <= 1'b0;
        end else begin
          acc     <= acc_nxt;
          cnt     <= cnt + 1'b1;
          sat_acc <= sat_acc | s2_sat;
        end
      end
    end
  end
`else
  assign e_out_o   = s2_err;
  assign e_valid_o = s2_valid;
  assign sat_o     = s2_sat;
`endif

endmodule

// File: tb/tb_gardner_ted_pipe.sv
// Directed bench for gardner_ted_pipe: two instances (WO=40 exact, WO=18 clipping) on one stimulus.
module tb_gardner_ted_pipe;

  logic clk = 1'b0;
  logic reset_n;
  logic signed [15:0] i_in, q_in;
  logic iq_val, sym_valid_i, mode_i;

  logic signed [39:0] ea_out;
  logic               ea_val, ea_sat;
  logic signed [15:0] ia_raw, qa_raw;
  logic signed [17:0] eb_out;
  logic               eb_val, eb_sat;
  logic signed [15:0] ib_raw, qb_raw;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gardner_ted_pipe #(.OSF(20), .WI(16), .WO(40), .ESHIFT(0), .RAW_DLY(20), .AVG_LOG2(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .i_in(i_in), .q_in(q_in), .iq_val(iq_val),
    .sym_valid_i(sym_valid_i), .mode_i(mode_i), .e_out_o(ea_out), .e_valid_o(ea_val),
    .sat_o(ea_sat), .i_raw_delay_o(ia_raw), .q_raw_delay_o(qa_raw)
  );

  gardner_ted_pipe #(.OSF(20), .WI(16), .WO(18), .ESHIFT(0), .RAW_DLY(5), .AVG_LOG2(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .i_in(i_in), .q_in(q_in), .iq_val(iq_val),
    .sym_valid_i(sym_valid_i), .mode_i(mode_i), .e_out_o(eb_out), .e_valid_o(eb_val),
    .sat_o(eb_sat), .i_raw_delay_o(ib_raw), .q_raw_delay_o(qb_raw)
  );

  task automatic step(input int i, input int q, input logic v, input logic s, input logic m);
    i_in = i[15:0];
    q_in = q[15:0];
    iq_val = v;
    sym_valid_i = s;
    mode_i = m;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_ea_out", ea_out, 0);
    check("rst_ea_val", ea_val, 0);
    check("rst_ea_sat", ea_sat, 0);
    check("rst_eb_val", eb_val, 0);
    check("rst_ia_raw", ia_raw, 0);
    check("rst_qb_raw", qb_raw, 0);
    reset_n = 1'b1;

`ifdef TED_AVG_EN
    for (int n = 1; n <= 21; n++) step(1, 0, 1, 0, 1);
    step(5, 0, 1, 1, 1);  check("avg_wait22", ea_val, 0);
    step(9, 0, 1, 1, 1);  check("avg_wait23", ea_val, 0);
    step(-3, 0, 1, 1, 1); check("avg_wait24", ea_val, 0);
    step(13, 0, 1, 1, 1); check("avg_wait25", ea_val, 0);
    step(1, 0, 1, 0, 1);  check("avg_wait26", ea_val, 0);
    step(1, 0, 1, 0, 1);
    check("avg_val", ea_val, 1);
    check("avg_out_a", ea_out, 5);
    check("avg_out_b", eb_out, 5);
    check("avg_sat_b", eb_sat, 0);
    step(1, 0, 1, 0, 1);  check("avg_pulse", ea_val, 0);
    step(1, 0, 1, 0, 1);
    step(5, 0, 1, 1, 1);
    step(9, 0, 1, 1, 1);
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    reset_n = 1'b0;
    step(0, 0, 0, 0, 0);  check("avg_rst_val0", ea_val, 0);
    step(0, 0, 0, 0, 0);  check("avg_rst_val1", eb_val, 0);
    reset_n = 1'b1;
    for (int n = 1; n <= 21; n++) step(1, 0, 1, 0, 1);
    for (int n = 22; n <= 25; n++) begin
      step(5, 0, 1, 1, 1);
      check("avg2_wait", ea_val, 0);
    end
    step(1, 0, 1, 0, 1);  check("avg2_wait26", ea_val, 0);
    step(1, 0, 1, 0, 1);
    check("avg2_val", ea_val, 1);
    check("avg2_out", ea_out, 4);
`else
    // I ramp 100/sample, Q=0: strobe on sample 20 falls in FILL, 21 and 22 qualify
    for (int n = 1; n <= 20; n++) step(100 * n, 0, 1, n == 20, 0);
    step(2100, 0, 1, 1, 0);
    check("fill_strobe_ignored", ea_val, 0);
    step(2200, 0, 1, 1, 0);
    check("k21_val", ea_val, 1);
    check("k21_out_a", ea_out, 2200000);
    check("k21_sat_a", ea_sat, 0);
    check("k21_out_b", eb_out, 131071);
    check("k21_sat_b", eb_sat, 1);
    step(2300, 0, 1, 0, 0);
    check("k22_val", ea_val, 1);
    check("k22_out_a", ea_out, 2400000);
    step(2400, 0, 1, 0, 0);
    check("pulse_end", ea_val, 0);

    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check("noval_strobe_s1", ea_val, 0);
    step(0, 0, 0, 0, 0);
    check("noval_strobe_s2", eb_val, 0);

    // Q ramp 50/sample from sample 25; mode toggles across back-to-back strobes
    for (int n = 25; n <= 49; n++) step(100 * n, 50 * n, 1, 0, 0);
    step(5000, 2500, 1, 1, 1);
    step(5100, 2550, 1, 1, 0);
    check("ionly_val", ea_val, 1);
    check("ionly_out", ea_out, 8000000);
    step(5200, 2600, 1, 0, 1);
    check("iq_out", ea_out, 10250000);
    check("iq_sat_b", eb_sat, 1);

    reset_n = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    for (int n = 1; n <= 23; n++) begin
      int vi, vq;
      vi = 0;
      vq = 0;
      case (n)
        1, 11: begin vi = 32767; vq = 32767; end
        2:     vi = 1;
        12:    vi = 5;
        21:    begin vi = -32768; vq = -32768; end
        22:    vi = 3;
        default: ;
      endcase
      step(vi, vq, 1, n >= 21, 0);
      if (n == 22) begin
        check("negsat_out_b", eb_out, -131072);
        check("negsat_sat_b", eb_sat, 1);
        check("negsat_out_a", ea_out, -64'sd4294770690);
      end
      if (n == 23) begin
        check("small_out_b", eb_out, 10);
        check("small_sat_b", eb_sat, 0);
        check("small_out_a", ea_out, 10);
      end
    end
    reset_n = 1'b0;
    step(0, 0, 0, 0, 0);
    check("midrst_val", ea_val, 0);
    step(0, 0, 0, 0, 0);
    check("midrst_out", eb_out, 0);
    reset_n = 1'b1;

    // impulse on sample 1; dut_b taps 6 ago, dut_a taps 21 ago
    for (int w = 1; w <= 22; w++) begin
      step(w == 1 ? 1000 : 0, w == 1 ? -77 : 0, 1, 0, 0);
      if (w == 5) check("raw_b_early", ib_raw, 0);
      if (w == 6) begin
        check("raw_b_i", ib_raw, 1000);
        check("raw_b_q", qb_raw, -77);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("raw_b_gap", ib_raw, 1000);
      end
      if (w == 7)  check("raw_b_late", ib_raw, 0);
      if (w == 20) check("raw_a_early", ia_raw, 0);
      if (w == 21) begin
        check("raw_a_i", ia_raw, 1000);
        check("raw_a_q", qa_raw, -77);
      end
      if (w == 22) check("raw_a_late", ia_raw, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
